// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_XLEN = 32;
   localparam logic [FETCH_XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_REQ   = 2'd0,
      FS_HOLD  = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic                  valid;
      logic [FETCH_XLEN-1:0] instr;
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] pc_plus4;
   } if_id_t;

   // Sequential PC; wraps mod 2^FETCH_XLEN.
   function automatic logic [FETCH_XLEN-1:0] calc_pc_plus4(input logic [FETCH_XLEN-1:0] pc);
      return pc + FETCH_XLEN'(4);
   endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble is inserted.
module if_id_register
   import fetch_pkg::*;
#(
   parameter logic [FETCH_XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   flush_i,
   input  logic   stall_i,
   input  logic   load_i,
   input  if_id_t data_i,
   output if_id_t q_o
);

   if_id_t q_q, q_d;

   // Next-state selection in priority order.
   always_comb begin
      q_d = q_q;
      if (flush_i) begin
         q_d.valid = 1'b0;
         q_d.instr = NOP_INSTR;
      end else if (stall_i) begin
         q_d = q_q;
      end else if (load_i) begin
         q_d = data_i;
      end else begin
         q_d.valid = 1'b0;
         q_d.instr = NOP_INSTR;
      end
   end

   // State register with asynchronous reset to an empty NOP slot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q.valid    <= 1'b0;
         q_q.instr    <= NOP_INSTR;
         q_q.pc       <= '0;
         q_q.pc_plus4 <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: issues imem requests for pc_i, absorbs wait states, stalls and
// flushes, and fills the IF/ID register. Optional IFETCH_PERF_CNT_EN adds fetch and
// wait-cycle counters. if_id_t is sized by FETCH_XLEN, so XLEN must match it.
module instruction_fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN      = FETCH_XLEN,
   parameter logic [XLEN-1:0]  NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_i,
   output logic            pc_en_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic            if_id_valid_o,
   output logic [XLEN-1:0] if_id_instr_o,
   output logic [XLEN-1:0] if_id_pc_o,
   output logic [XLEN-1:0] if_id_pc_plus4_o
`ifdef IFETCH_PERF_CNT_EN
  ,output logic [31:0]     fetch_count_o,
   output logic [31:0]     wait_cycles_o
`endif
);

   fetch_state_t    state_q, state_d;
   if_id_t          buf_q, buf_d;
   logic [XLEN-1:0] drain_addr_q, drain_addr_d;

   if_id_t          fetch_word;
   if_id_t          if_id_q;
   logic            req;
   logic            in_req, in_hold;
   logic            if_id_load;

   assign in_req  = (state_q == FS_REQ);
   assign in_hold = (state_q == FS_HOLD);

   assign fetch_word = '{valid: 1'b1, instr: imem_rdata_i, pc: pc_i,
                         pc_plus4: calc_pc_plus4(pc_i)};

   // Memory request and address; both held stable until imem_ready_i.
   always_comb begin
      req         = 1'b0;
      imem_addr_o = pc_i;
      case (state_q)
         FS_REQ:   req = 1'b1;
         FS_DRAIN: begin
            req         = 1'b1;
            imem_addr_o = drain_addr_q;
         end
         default:  req = 1'b0;
      endcase
   end

   assign imem_req_o = req & ~reset;
   // PC advances on a completed fetch or loads the redirect target on a flush.
   assign pc_en_o    = ~reset & (flush_i | (in_req & imem_ready_i));

   // FSM next state, skid buffer and drain address.
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      drain_addr_d = drain_addr_q;
      case (state_q)
         FS_REQ: begin
            if (imem_ready_i) begin
               if (!flush_i && stall_i) begin
                  buf_d   = fetch_word;
                  state_d = FS_HOLD;
               end
            end else if (flush_i) begin
               // Outstanding request must complete at its original address.
               drain_addr_d = pc_i;
               state_d      = FS_DRAIN;
            end
         end
         FS_HOLD: begin
            if (flush_i || !stall_i) state_d = FS_REQ;
         end
         FS_DRAIN: begin
            if (imem_ready_i) state_d = FS_REQ;
         end
         default: state_d = FS_REQ;
      endcase
   end

   // FSM, buffer and drain-address registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FS_REQ;
         buf_q        <= '0;
         drain_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   // HOLD only reaches the load path once stall and flush are both low.
   assign if_id_load = (in_req & imem_ready_i) | in_hold;

   if_id_register #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk_i   (clk),
      .rst_i   (reset),
      .flush_i (flush_i),
      .stall_i (stall_i),
      .load_i  (if_id_load),
      .data_i  (in_hold ? buf_q : fetch_word),
      .q_o     (if_id_q)
   );

   assign if_id_valid_o    = if_id_q.valid;
   assign if_id_instr_o    = if_id_q.instr;
   assign if_id_pc_o       = if_id_q.pc;
   assign if_id_pc_plus4_o = if_id_q.pc_plus4;

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, wait_cycles_q;
   logic        word_used;

   // A word counts only when it actually enters IF/ID.
   assign word_used = ~flush_i & ~stall_i & if_id_load;

   // Free-running wrapping performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count_q <= '0;
         wait_cycles_q <= '0;
      end else begin
         if (word_used) fetch_count_q <= fetch_count_q + 32'd1;
         if (req && !imem_ready_i) wait_cycles_q <= wait_cycles_q + 32'd1;
      end
   end

   assign fetch_count_o = fetch_count_q;
   assign wait_cycles_o = wait_cycles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage with a scoreboard of expected IF/ID words.
module tb_instruction_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_i;
   logic        pc_en_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;
   logic        stall_i;
   logic        flush_i;
   logic        if_id_valid_o;
   logic [31:0] if_id_instr_o;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_pc_plus4_o;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count_o;
   logic [31:0] wait_cycles_o;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic last_stall;

   instruction_fetch_stage u_dut (
      .clk              (clk),
      .reset            (reset),
      .pc_i             (pc_i),
      .pc_en_o          (pc_en_o),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_ready_i     (imem_ready_i),
      .imem_rdata_i     (imem_rdata_i),
      .stall_i          (stall_i),
      .flush_i          (flush_i),
      .if_id_valid_o    (if_id_valid_o),
      .if_id_instr_o    (if_id_instr_o),
      .if_id_pc_o       (if_id_pc_o),
      .if_id_pc_plus4_o (if_id_pc_plus4_o)
`ifdef IFETCH_PERF_CNT_EN
     ,.fetch_count_o    (fetch_count_o),
      .wait_cycles_o    (wait_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Inputs change just after the falling edge; registered outputs are sampled at it.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      e.pc4   = pc + 32'd4;
      sb_q.push_back(e);
   endtask

   always @(posedge clk) last_stall <= stall_i;

   // A newly loaded IF/ID word (not a stall-held one) must match the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && if_id_valid_o === 1'b1 && last_stall === 1'b0) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_valid", {31'b0, if_id_valid_o}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq("sb_instr", if_id_instr_o, e.instr);
            check_eq("sb_pc", if_id_pc_o, e.pc);
            check_eq("sb_pc4", if_id_pc_plus4_o, e.pc4);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      pc_i         = 32'h0000_0040;
      imem_ready_i = 1'b0;
      imem_rdata_i = '0;
      stall_i      = 1'b0;
      flush_i      = 1'b0;
      repeat (2) cyc();
      check_eq("rst_req", {31'b0, imem_req_o}, 32'd0);
      check_eq("rst_pc_en", {31'b0, pc_en_o}, 32'd0);
      check_eq("rst_valid", {31'b0, if_id_valid_o}, 32'd0);
      check_eq("rst_instr", if_id_instr_o, NOP);
      check_eq("rst_pc", if_id_pc_o, 32'd0);
      check_eq("rst_pc4", if_id_pc_plus4_o, 32'd0);
      reset = 1'b0;
      cyc();
      check_eq("rel_req", {31'b0, imem_req_o}, 32'd1);
      check_eq("rel_addr", imem_addr_o, 32'h0000_0040);

      // Zero-wait fetch.
      pc_i = 32'h0000_0F0C; imem_rdata_i = 32'hECAB_1234; imem_ready_i = 1'b1;
      #1 check_eq("t2_pc_en", {31'b0, pc_en_o}, 32'd1);
      push(32'hECAB_1234, 32'h0000_0F0C);
      cyc();
      check_eq("t2_valid", {31'b0, if_id_valid_o}, 32'd1);

      // Reset in the middle of a pending request.
      pc_i = 32'h0000_0200; imem_ready_i = 1'b0; reset = 1'b1;
      #1;
      check_eq("t1_valid", {31'b0, if_id_valid_o}, 32'd0);
      check_eq("t1_instr", if_id_instr_o, NOP);
      check_eq("t1_req", {31'b0, imem_req_o}, 32'd0);
      check_eq("t1_pc_en", {31'b0, pc_en_o}, 32'd0);
      cyc();
      reset = 1'b0;
      cyc();
      check_eq("t1_rel_req", {31'b0, imem_req_o}, 32'd1);
      check_eq("t1_rel_addr", imem_addr_o, 32'h0000_0200);

      // Three wait states, then the response.
      pc_i = 32'h0000_0F10;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("t3_pc_en", {31'b0, pc_en_o}, 32'd0);
         check_eq("t3_addr", imem_addr_o, 32'h0000_0F10);
         cyc();
         check_eq("t3_valid", {31'b0, if_id_valid_o}, 32'd0);
      end
      imem_ready_i = 1'b1; imem_rdata_i = 32'h1111_2222;
      #1 check_eq("t3_pc_en_rdy", {31'b0, pc_en_o}, 32'd1);
      push(32'h1111_2222, 32'h0000_0F10);
      cyc();
      check_eq("t3_valid_rdy", {31'b0, if_id_valid_o}, 32'd1);

      // Stall on response: word parks in the buffer, IF/ID held.
      pc_i = 32'h0000_0F14; imem_rdata_i = 32'h3333_4444; stall_i = 1'b1;
      #1 check_eq("t4_pc_en", {31'b0, pc_en_o}, 32'd1);
      push(32'h3333_4444, 32'h0000_0F14);
      cyc();
      imem_ready_i = 1'b0; pc_i = 32'h0000_0F18;
      #1;
      check_eq("t4_req", {31'b0, imem_req_o}, 32'd0);
      check_eq("t4_pc_en_hold", {31'b0, pc_en_o}, 32'd0);
      check_eq("t4_held_instr", if_id_instr_o, 32'h1111_2222);
      check_eq("t4_held_pc", if_id_pc_o, 32'h0000_0F10);
      cyc();
      check_eq("t4_req_hold2", {31'b0, imem_req_o}, 32'd0);
      stall_i = 1'b0;
      #1 check_eq("t4_pc_en_rel", {31'b0, pc_en_o}, 32'd0);
      cyc();
      check_eq("t4_buf_instr", if_id_instr_o, 32'h3333_4444);
      check_eq("t4_req_back", {31'b0, imem_req_o}, 32'd1);
      check_eq("t4_addr_back", imem_addr_o, 32'h0000_0F18);

      // Flush while waiting: drain the old request at its original address.
      pc_i = 32'h0000_0100;
      cyc();
      check_eq("t5_valid_wait", {31'b0, if_id_valid_o}, 32'd0);
      check_eq("t5_addr_wait", imem_addr_o, 32'h0000_0100);
      flush_i = 1'b1;
      #1 check_eq("t5_pc_en_flush", {31'b0, pc_en_o}, 32'd1);
      cyc();
      flush_i = 1'b0; pc_i = 32'h0000_0500;
      #1;
      check_eq("t5_drain_req", {31'b0, imem_req_o}, 32'd1);
      check_eq("t5_drain_addr", imem_addr_o, 32'h0000_0100);
      check_eq("t5_drain_pc_en", {31'b0, pc_en_o}, 32'd0);
      check_eq("t5_drain_valid", {31'b0, if_id_valid_o}, 32'd0);
      cyc();
      check_eq("t5_drain_addr2", imem_addr_o, 32'h0000_0100);
      imem_ready_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
      #1 check_eq("t5_drain_rdy_pc_en", {31'b0, pc_en_o}, 32'd0);
      cyc();
      check_eq("t5_discard_valid", {31'b0, if_id_valid_o}, 32'd0);
      imem_ready_i = 1'b0;
      #1 check_eq("t5_new_addr", imem_addr_o, 32'h0000_0500);

      // PC+4 wrap, then flush and stall together.
      pc_i = 32'hFFFF_FFFC; imem_ready_i = 1'b1; imem_rdata_i = 32'hABCD_0001;
      push(32'hABCD_0001, 32'hFFFF_FFFC);
      cyc();
      check_eq("t6_pc4_wrap", if_id_pc_plus4_o, 32'h0000_0000);
      pc_i = 32'h0000_0000; imem_rdata_i = 32'h0000_0077; flush_i = 1'b1; stall_i = 1'b1;
      #1 check_eq("t6_pc_en", {31'b0, pc_en_o}, 32'd1);
      cyc();
      check_eq("t6_flush_stall_valid", {31'b0, if_id_valid_o}, 32'd0);
      check_eq("t6_flush_stall_instr", if_id_instr_o, NOP);
      flush_i = 1'b0; stall_i = 1'b0;

      // Flush while holding a buffered word discards it.
      pc_i = 32'h0000_0020; imem_rdata_i = 32'h5555_5555; stall_i = 1'b1;
      cyc();
      imem_ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b1;
      #1;
      check_eq("hf_req", {31'b0, imem_req_o}, 32'd0);
      check_eq("hf_pc_en", {31'b0, pc_en_o}, 32'd1);
      cyc();
      flush_i = 1'b0;
      check_eq("hf_valid", {31'b0, if_id_valid_o}, 32'd0);
      #1 check_eq("hf_req_back", {31'b0, imem_req_o}, 32'd1);

      // Back-to-back fetches: one instruction per cycle.
      imem_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pc_i = 32'h0000_1000 + 32'(4 * i);
         imem_rdata_i = $urandom;
         push(imem_rdata_i, pc_i);
         cyc();
         check_eq("burst_valid", {31'b0, if_id_valid_o}, 32'd1);
      end
      imem_ready_i = 1'b0;
      repeat (2) cyc();
      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
